// File: rtl/coord_point_sequencer_if.sv
// coord_point_sequencer_if: upstream, core and result signals of the point sequencer
interface coord_point_sequencer_if #(
  parameter int N  = 3,
  parameter int CW = 8
);
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_x, in_y, in_z;
  logic          core_start;
  logic [N-1:0]  core_x, core_y, core_z;
  logic          core_done;
  logic [N-1:0]  core_x_out, core_y_out, core_z_out;
  logic          res_valid;
  logic [N-1:0]  res_x, res_y, res_z;
  logic          res_match;
  logic          res_timeout;
  logic          busy;
  logic [CW-1:0] pass_count, fail_count, timeout_count;
  modport slave (
    input  in_valid, in_x, in_y, in_z, core_done, core_x_out, core_y_out, core_z_out,
    output in_ready, core_start, core_x, core_y, core_z, res_valid, res_x, res_y, res_z,
           res_match, res_timeout, busy, pass_count, fail_count, timeout_count
  );
  modport master (
    output in_valid, in_x, in_y, in_z, core_done, core_x_out, core_y_out, core_z_out,
    input  in_ready, core_start, core_x, core_y, core_z, res_valid, res_x, res_y, res_z,
           res_match, res_timeout, busy, pass_count, fail_count, timeout_count
  );
endinterface

// File: rtl/coord_point_sequencer.sv
// coord_point_sequencer: FIFO-buffered feeder that runs each triple through the core and scores the result
module coord_point_sequencer #(
  parameter int N            = 3,
  parameter int DEPTH        = 4,
  parameter int START_CYCLES = 2,
  parameter int TIMEOUT      = 255,
  parameter int CW           = 8
) (
  input logic                    clk,
  input logic                    reset,
  coord_point_sequencer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(START_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT);
  localparam int W  = 3 * N;
  typedef enum logic [1:0] {IDLE, START, WAIT, REPORT} state_t;
  state_t        state_q, state_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [W-1:0]  hold_q, hold_d, res_q, res_d, got;
  logic [SW-1:0] sc_q, sc_d;
  logic [TW-1:0] wd_q, wd_d;
  logic          armed_q, armed_d, match_q, match_d, to_q, to_d;
  logic [CW-1:0] pass_q, pass_d, fail_q, fail_d, tout_q, tout_d;
  logic          full, empty, push, pop;
  always_comb begin
    full    = cnt_q == (AW+1)'(DEPTH);
    empty   = cnt_q == '0;
    push    = bus.in_valid && !full;
    pop     = state_q == IDLE && !empty;
    got     = {bus.core_x_out, bus.core_y_out, bus.core_z_out};
    wp_d    = push ? wp_q + AW'(1) : wp_q;
    rp_d    = pop ? rp_q + AW'(1) : rp_q;
    cnt_d   = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    state_d = state_q;
    hold_d  = hold_q;
    res_d   = res_q;
    sc_d    = sc_q;
    wd_d    = wd_q;
    armed_d = armed_q;
    match_d = match_q;
    to_d    = to_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    tout_d  = tout_q;
    case (state_q)
      IDLE: if (pop) begin
        hold_d  = mem_q[rp_q];
        sc_d    = '0;
        state_d = START;
      end
      START: begin
        sc_d    = sc_q + SW'(1);
        armed_d = 1'b0;
        wd_d    = '0;
        state_d = sc_q == SW'(START_CYCLES - 1) ? WAIT : START;
      end
      WAIT: begin
        armed_d = armed_q || !bus.core_done;
        if (armed_q && bus.core_done) begin
          res_d   = got;
          match_d = got == hold_q;
          to_d    = 1'b0;
          state_d = REPORT;
        end else if (wd_q == TW'(TIMEOUT - 1)) begin
          res_d   = '0;
          match_d = 1'b0;
          to_d    = 1'b1;
          state_d = REPORT;
        end else
          wd_d = wd_q + TW'(1);
      end
      default: begin
        pass_d  = pass_q + CW'(match_q && pass_q != '1);
        tout_d  = tout_q + CW'(to_q && tout_q != '1);
        fail_d  = fail_q + CW'(!match_q && !to_q && fail_q != '1);
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
      hold_q  <= '0;
      res_q   <= '0;
      sc_q    <= '0;
      wd_q    <= '0;
      armed_q <= 1'b0;
      match_q <= 1'b0;
      to_q    <= 1'b0;
      pass_q  <= '0;
      fail_q  <= '0;
      tout_q  <= '0;
    end else begin
      state_q <= state_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      res_q   <= res_d;
      sc_q    <= sc_d;
      wd_q    <= wd_d;
      armed_q <= armed_d;
      match_q <= match_d;
      to_q    <= to_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      tout_q  <= tout_d;
    end
  end
  always_ff @(posedge clk)
    if (push) mem_q[wp_q] <= {bus.in_x, bus.in_y, bus.in_z};
  assign bus.in_ready                       = !full;
  assign bus.core_start                     = state_q == START;
  assign {bus.core_x, bus.core_y, bus.core_z} = hold_q;
  assign bus.res_valid                      = state_q == REPORT;
  assign {bus.res_x, bus.res_y, bus.res_z}    = res_q;
  assign bus.res_match                      = match_q;
  assign bus.res_timeout                    = to_q;
  assign bus.busy                           = state_q != IDLE;
  assign bus.pass_count                     = pass_q;
  assign bus.fail_count                     = fail_q;
  assign bus.timeout_count                  = tout_q;
endmodule

// File: tb/tb_coord_point_sequencer.sv
// tb_coord_point_sequencer: directed scenarios against a behavioural core model
module tb_coord_point_sequencer;
  localparam int N = 3, DEPTH = 4, SC = 2, TO = 30, CW = 2;
  localparam int ECHO = 0, MISM = 1, HUNG = 2, NEVER = 3;
  typedef struct {logic [N-1:0] x, y, z; logic m, t;} res_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int vec = 0, err = 0;
  int mode = NEVER, dly = 1, cnt = 0, start_cnt = 0;
  res_t rq[$];
  always #5 clk = ~clk;
  coord_point_sequencer_if #(.N(N), .CW(CW)) bus();
  coord_point_sequencer #(.N(N), .DEPTH(DEPTH), .START_CYCLES(SC), .TIMEOUT(TO), .CW(CW)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  always @(negedge clk) begin
    if (mode == HUNG) bus.core_done = 1'b1;
    else if (bus.core_start) begin
      cnt = 0;
      bus.core_done = 1'b0;
    end else if (mode == ECHO || mode == MISM) begin
      if (cnt >= dly) bus.core_done = 1'b1;
      else cnt++;
    end else bus.core_done = 1'b0;
    bus.core_x_out = bus.core_x;
    bus.core_y_out = bus.core_y;
    bus.core_z_out = bus.core_z + N'(mode == MISM);
  end
  always @(negedge clk) begin
    if (bus.core_start) start_cnt++;
    if (bus.res_valid) rq.push_back(res_t'{bus.res_x, bus.res_y, bus.res_z, bus.res_match, bus.res_timeout});
  end
  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation did not finish");
  end
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    rq.delete();
  endtask
  task automatic push(input logic [N-1:0] x, input logic [N-1:0] y, input logic [N-1:0] z);
    int k = 0;
    @(negedge clk);
    while (!bus.in_ready && k < 300) begin
      @(negedge clk);
      k++;
    end
    vec++;
    if (!bus.in_ready) begin err++; $display("FAIL push_ready got 0 exp 1"); end
    bus.in_x = x;
    bus.in_y = y;
    bus.in_z = z;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask
  task automatic wait_res(input int n);
    int k = 0;
    while (rq.size() < n && k < 600) begin
      @(negedge clk);
      k++;
    end
    vec++;
    if (rq.size() < n) begin err++; $display("FAIL wait_res got %0d results exp %0d", rq.size(), n); end
  endtask
  task automatic wait_start_fall(input string tag);
    int k = 0;
    while (!bus.core_start && k < 300) begin @(negedge clk); k++; end
    while (bus.core_start && k < 300) begin @(negedge clk); k++; end
    vec++;
    if (k >= 300) begin err++; $display("FAIL %s start_window got none exp core_start pulse", tag); end
  endtask
  task automatic check_reset_state(input string tag);
    vec++; if (bus.in_ready !== 1'b1) begin err++; $display("FAIL %s in_ready got %b exp 1", tag, bus.in_ready); end
    vec++; if (bus.core_start !== 1'b0) begin err++; $display("FAIL %s core_start got %b exp 0", tag, bus.core_start); end
    vec++; if ({bus.core_x, bus.core_y, bus.core_z} !== '0) begin err++; $display("FAIL %s core_xyz got %h exp 0", tag, {bus.core_x, bus.core_y, bus.core_z}); end
    vec++; if (bus.res_valid !== 1'b0) begin err++; $display("FAIL %s res_valid got %b exp 0", tag, bus.res_valid); end
    vec++; if ({bus.res_x, bus.res_y, bus.res_z} !== '0) begin err++; $display("FAIL %s res_xyz got %h exp 0", tag, {bus.res_x, bus.res_y, bus.res_z}); end
    vec++; if ({bus.res_match, bus.res_timeout} !== 2'b00) begin err++; $display("FAIL %s match_timeout got %b exp 00", tag, {bus.res_match, bus.res_timeout}); end
    vec++; if (bus.busy !== 1'b0) begin err++; $display("FAIL %s busy got %b exp 0", tag, bus.busy); end
    vec++; if ({bus.pass_count, bus.fail_count, bus.timeout_count} !== '0) begin err++; $display("FAIL %s counters got %h exp 0", tag, {bus.pass_count, bus.fail_count, bus.timeout_count}); end
  endtask
  task automatic test_reset();
    do_reset();
    @(negedge clk);
    check_reset_state("reset");
  endtask
  task automatic test_single();
    mode = ECHO;
    dly = 4;
    start_cnt = 0;
    rq.delete();
    push(3'd5, 3'd3, 3'd6);
    wait_res(1);
    repeat (2) @(negedge clk);
    vec++; if (start_cnt !== 2) begin err++; $display("FAIL single_start_cycles got %0d exp 2", start_cnt); end
    if (rq.size() > 0) begin
      vec++; if ({rq[0].x, rq[0].y, rq[0].z} !== {3'd5, 3'd3, 3'd6}) begin err++; $display("FAIL single_res got %0d,%0d,%0d exp 5,3,6", rq[0].x, rq[0].y, rq[0].z); end
      vec++; if ({rq[0].m, rq[0].t} !== 2'b10) begin err++; $display("FAIL single_verdict got %b exp 10", {rq[0].m, rq[0].t}); end
    end
    vec++; if (rq.size() !== 1) begin err++; $display("FAIL single_res_count got %0d exp 1", rq.size()); end
    vec++; if (bus.pass_count !== 2'd1) begin err++; $display("FAIL single_pass got %0d exp 1", bus.pass_count); end
    vec++; if (bus.busy !== 1'b0) begin err++; $display("FAIL single_busy_after got %b exp 0", bus.busy); end
  endtask
  task automatic test_latency();
    int n = 0;
    mode = ECHO;
    dly = 1;
    @(negedge clk);
    {bus.in_x, bus.in_y, bus.in_z} = {3'd2, 3'd4, 3'd7};
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    while (n < 50) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (bus.res_valid) break;
    end
    vec++; if (n !== 5) begin err++; $display("FAIL latency got %0d cycles exp 5", n); end
    vec++; if (bus.res_match !== 1'b1) begin err++; $display("FAIL latency_match got %b exp 1", bus.res_match); end
    repeat (2) @(negedge clk);
  endtask
  task automatic test_mismatch();
    mode = MISM;
    dly = 4;
    rq.delete();
    push(3'd1, 3'd2, 3'd3);
    wait_res(1);
    repeat (2) @(negedge clk);
    if (rq.size() > 0) begin
      vec++; if ({rq[0].x, rq[0].y, rq[0].z} !== {3'd1, 3'd2, 3'd4}) begin err++; $display("FAIL mismatch_res got %0d,%0d,%0d exp 1,2,4", rq[0].x, rq[0].y, rq[0].z); end
      vec++; if ({rq[0].m, rq[0].t} !== 2'b00) begin err++; $display("FAIL mismatch_verdict got %b exp 00", {rq[0].m, rq[0].t}); end
    end
    vec++; if (bus.fail_count !== 2'd1) begin err++; $display("FAIL mismatch_fail got %0d exp 1", bus.fail_count); end
    vec++; if (bus.pass_count !== 2'd2) begin err++; $display("FAIL mismatch_pass got %0d exp 2", bus.pass_count); end
  endtask
  task automatic test_timeout();
    int n = 0;
    mode = HUNG;
    push(3'd7, 3'd7, 3'd7);
    wait_start_fall("timeout");
    while (n < 3 * TO) begin
      if (bus.res_valid) break;
      @(negedge clk);
      n++;
    end
    vec++; if (n !== TO) begin err++; $display("FAIL timeout_cycles got %0d exp %0d", n, TO); end
    vec++; if ({bus.res_x, bus.res_y, bus.res_z} !== '0) begin err++; $display("FAIL timeout_res got %h exp 0", {bus.res_x, bus.res_y, bus.res_z}); end
    vec++; if ({bus.res_match, bus.res_timeout} !== 2'b01) begin err++; $display("FAIL timeout_verdict got %b exp 01", {bus.res_match, bus.res_timeout}); end
    repeat (2) @(negedge clk);
    vec++; if (bus.timeout_count !== 2'd1) begin err++; $display("FAIL timeout_count got %0d exp 1", bus.timeout_count); end
    vec++; if ({bus.res_valid, bus.res_timeout} !== 2'b01) begin err++; $display("FAIL timeout_hold got %b exp 01", {bus.res_valid, bus.res_timeout}); end
  endtask
  task automatic test_back_to_back_full();
    int k = 0;
    bit held = 1'b1;
    do_reset();
    mode = NEVER;
    push(3'd1, 3'd6, 3'd2);
    repeat (4) @(negedge clk);
    for (int i = 2; i <= 5; i++) push(N'(i), N'(7 - i), N'(i) ^ 3'd3);
    @(negedge clk);
    vec++; if (bus.in_ready !== 1'b0) begin err++; $display("FAIL full_in_ready got %b exp 0", bus.in_ready); end
    {bus.in_x, bus.in_y, bus.in_z} = {3'd6, 3'd1, 3'd5};
    bus.in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (bus.in_ready !== 1'b0) held = 1'b0;
    end
    vec++; if (!held) begin err++; $display("FAIL full_held_off got ready exp not ready"); end
    mode = ECHO;
    dly = 2;
    while (!bus.in_ready && k < 300) begin @(negedge clk); k++; end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    wait_res(6);
    for (int i = 0; i < rq.size() && i < 6; i++) begin
      vec++;
      if ({rq[i].x, rq[i].y, rq[i].z, rq[i].m} !== {N'(i + 1), N'(6 - i), N'(i + 1) ^ 3'd3, 1'b1}) begin
        err++;
        $display("FAIL order_%0d got %0d,%0d,%0d m%b exp %0d,%0d,%0d m1", i, rq[i].x, rq[i].y, rq[i].z, rq[i].m, i + 1, 6 - i, (i + 1) ^ 3);
      end
    end
  endtask
  task automatic test_saturation();
    do_reset();
    mode = ECHO;
    dly = 1;
    for (int i = 1; i <= 5; i++) push(N'(i), N'(i), N'(i));
    wait_res(5);
    repeat (3) @(negedge clk);
    vec++; if (bus.pass_count !== 2'd3) begin err++; $display("FAIL sat_pass got %0d exp 3", bus.pass_count); end
    vec++; if ({bus.fail_count, bus.timeout_count} !== 4'd0) begin err++; $display("FAIL sat_others got %h exp 0", {bus.fail_count, bus.timeout_count}); end
  endtask
  task automatic test_mid_reset();
    do_reset();
    mode = ECHO;
    dly = 2;
    for (int i = 1; i <= 3; i++) push(N'(i), N'(i), N'(i));
    wait_res(1);
    mode = NEVER;
    wait_start_fall("mid_reset");
    repeat (3) @(negedge clk);
    vec++; if ({bus.busy, bus.core_x} !== {1'b1, 3'd2}) begin err++; $display("FAIL mid_in_wait got %b,%0d exp 1,2", bus.busy, bus.core_x); end
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_reset_state("mid_reset");
    rq.delete();
    mode = ECHO;
    repeat (3 * TO) @(negedge clk);
    vec++; if (rq.size() !== 0) begin err++; $display("FAIL mid_no_result got %0d results exp 0", rq.size()); end
    vec++; if (bus.busy !== 1'b0) begin err++; $display("FAIL mid_idle got %b exp 0", bus.busy); end
  endtask
  initial begin
    bus.in_valid = 1'b0;
    {bus.in_x, bus.in_y, bus.in_z} = '0;
    bus.core_done = 1'b0;
    {bus.core_x_out, bus.core_y_out, bus.core_z_out} = '0;
    test_reset();
    test_single();
    test_latency();
    test_mismatch();
    test_timeout();
    test_back_to_back_full();
    test_saturation();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
